// File: rtl/demux_1ton_buffered_pkg.sv
// demux_1ton_buffered_pkg: shared defaults and select-width helper for the buffered demux
package demux_1ton_buffered_pkg;
  localparam int DEF_N = 32;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_CNT_W = 8;
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/demux_1ton_buffered_slot.sv
// demux_1ton_buffered_slot: one-entry output buffer with drain-and-refill
module demux_1ton_buffered_slot #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         free
);
  logic [N-1:0] data;
  assign free = !out_valid || out_ready;
  assign out_data = out_valid ? data : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      data <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_1ton_buffered.sv
// demux_1ton_buffered: registered 1-to-NUM_OUT demux with per-channel slots, broadcast and drop counting
module demux_1ton_buffered
  import demux_1ton_buffered_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int SEL_W = sel_width(NUM_OUT),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_bcast,
  output logic [NUM_OUT-1:0]   out_valid,
  input  logic [NUM_OUT-1:0]   out_ready,
  output logic [NUM_OUT*N-1:0] out_data,
  output logic                 err_sel,
  output logic [CNT_W-1:0]     drop_cnt
);
  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;
  logic in_range;
  logic accept;
  logic drop;
  assign in_range = {1'b0, in_sel} < (SEL_W+1)'(NUM_OUT);
  // out-of-range selects are always ready so the word can be consumed and dropped
  assign in_ready = in_bcast ? &free : (in_range ? free[in_sel] : 1'b1);
  assign accept = in_valid && in_ready;
  assign drop = accept && !in_bcast && !in_range;
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    assign load[i] = accept && (in_bcast || (in_range && in_sel == SEL_W'(i)));
    demux_1ton_buffered_slot #(.N(N)) u_slot (
      .clk(clk),
      .rst(rst),
      .load(load[i]),
      .load_data(in_data),
      .out_ready(out_ready[i]),
      .out_valid(out_valid[i]),
      .out_data(out_data[i*N +: N]),
      .free(free[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= drop;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_1ton_buffered.sv
// tb_demux_1ton_buffered: directed checks for the buffered demux (NUM_OUT=4 and NUM_OUT=3 instances)
module tb_demux_1ton_buffered;
  logic clk = 0;
  logic rst;
  logic in_valid, in_ready, in_bcast, err_sel;
  logic [31:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid, out_ready;
  logic [127:0] out_data;
  logic [7:0] drop_cnt;
  logic v3, ready3, err3;
  logic [31:0] data3;
  logic [1:0] sel3;
  logic [2:0] ov3, or3;
  logic [95:0] od3;
  logic [7:0] cnt3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1ton_buffered #(.N(32), .NUM_OUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_sel(err_sel), .drop_cnt(drop_cnt)
  );

  demux_1ton_buffered #(.N(32), .NUM_OUT(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ready3), .in_data(data3),
    .in_sel(sel3), .in_bcast(1'b0), .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .err_sel(err3), .drop_cnt(cnt3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 1; in_data = 32'h12345678; in_sel = 0; in_bcast = 0; out_ready = 0;
    v3 = 0; data3 = 0; sel3 = 0; or3 = 0;
    tick; tick;
    rst = 0; in_valid = 0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", out_valid); end
    checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", drop_cnt); end
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single;
    in_valid = 1; in_data = 32'hDEADBEEF; in_sel = 2; out_ready = 0;
    tick;
    in_valid = 0;
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got %b want 0100", out_valid); end
    checks++; if (out_data !== {32'd0, 32'hDEADBEEF, 32'd0, 32'd0}) begin errors++; $display("FAIL single_data got %h", out_data); end
    checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err_sel); end
    in_valid = 1; in_data = 32'h1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", in_ready); end
    for (int s = 0; s < 4; s++) begin
      if (s != 2) begin
        in_sel = 2'(s); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_other%0d got %b want 1", s, in_ready); end
      end
    end
    in_valid = 0; out_ready = 4'b0100;
    tick;
    out_ready = 0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got %b want 0000", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 4'b0010; in_valid = 1; in_sel = 1;
    for (int k = 0; k < 8; k++) begin
      in_data = k; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", k, in_ready); end
      tick;
      checks++; if (out_valid !== 4'b0010 || out_data[63:32] !== 32'(k)) begin
        errors++; $display("FAIL b2b_out%0d got v=%b d=%0d want v=0010 d=%0d", k, out_valid, out_data[63:32], k);
      end
    end
    in_valid = 0;
    tick;
    out_ready = 0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_empty got %b want 0000", out_valid); end
  endtask

  task automatic test_broadcast;
    in_valid = 1; in_sel = 3; in_data = 32'd33;
    tick;
    in_bcast = 1; in_data = 32'hA5A5A5A5; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bcast_block got %b want 0", in_ready); end
    tick;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bcast_block2 got %b want 0", in_ready); end
    checks++; if (out_valid !== 4'b1000 || out_data !== {32'd33, 96'd0}) begin
      errors++; $display("FAIL bcast_hold got v=%b d=%h want v=1000 ch3=33", out_valid, out_data);
    end
    out_ready = 4'b1000; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready got %b want 1", in_ready); end
    tick;
    in_valid = 0; in_bcast = 0; out_ready = 0;
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL bcast_valid got %b want 1111", out_valid); end
    checks++; if (out_data !== {4{32'hA5A5A5A5}}) begin errors++; $display("FAIL bcast_data got %h", out_data); end
    out_ready = 4'b1111;
    tick;
    out_ready = 0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bcast_drain got %b want 0000", out_valid); end
  endtask

  task automatic test_reset_mid;
    in_valid = 1; in_sel = 0; in_data = 32'h11;
    tick;
    in_sel = 2; in_data = 32'h22;
    tick;
    checks++; if (out_valid !== 4'b0101) begin errors++; $display("FAIL mid_fill got %b want 0101", out_valid); end
    in_sel = 1; in_data = 32'h77; rst = 1;
    tick;
    rst = 0; in_valid = 0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_valid got %b want 0000", out_valid); end
    checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL mid_data got %h want 0", out_data); end
  endtask

  task automatic test_drop;
    v3 = 1; sel3 = 3; data3 = 32'hCAFE; or3 = 0; #1;
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", ready3); end
    for (int k = 1; k <= 300; k++) begin
      tick;
      checks++; if (err3 !== 1'b1 || ov3 !== 3'b000) begin errors++; $display("FAIL drop_pulse%0d got err=%b v=%b want 1 000", k, err3, ov3); end
      if (k == 1 || k == 100 || k == 255 || k == 300) begin
        checks++; if (cnt3 !== 8'((k > 255) ? 255 : k)) begin errors++; $display("FAIL drop_cnt%0d got %0d want %0d", k, cnt3, (k > 255) ? 255 : k); end
      end
    end
    v3 = 0;
    tick;
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL drop_idle_err got %b want 0", err3); end
    checks++; if (cnt3 !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", cnt3); end
    v3 = 1; sel3 = 1; data3 = 32'hBEEF;
    tick;
    v3 = 0;
    checks++; if (ov3 !== 3'b010 || od3 !== {32'd0, 32'hBEEF, 32'd0} || err3 !== 1'b0) begin
      errors++; $display("FAIL drop_inrange got v=%b d=%h err=%b", ov3, od3, err3);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_broadcast;
    test_reset_mid;
    test_drop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
